// File: rtl/program_memory_arbiter_pkg.sv
// program_memory_arbiter_pkg: shared state encoding and port ids for the program memory arbiter
package program_memory_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/program_memory_arbiter_if.sv
// program_memory_arbiter_if: fetch port, data port and byte-wide program memory bus
interface program_memory_arbiter_if #(parameter int ADDR_W = 32);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic if_ack;
  logic [31:0] if_rdata;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0] d_wdata;
  logic d_ack;
  logic [31:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/program_memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, bit 0 = fetch port, bit 1 = data port
module rr_arbiter2
  import program_memory_arbiter_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic en,
  input logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  // on a tie the port not granted last wins
  always_comb gnt = &req ? (last == PORT_D ? 2'b01 : 2'b10) : req;
  // remember who won so the next tie goes the other way
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= PORT_D;
    else if (en && |req) last <= gnt[1];
endmodule

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares a byte-wide program memory between fetch and data word ports
module program_memory_arbiter
  import program_memory_arbiter_pkg::*;
#(parameter int ADDR_W = 32) (
  input logic clk,
  input logic reset,
  program_memory_arbiter_if.slave bus
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  state_t state;
  logic [1:0] cnt;
  logic [1:0] gnt;
  logic owner;
  logic [23:0] wd;
  logic [23:0] word_q;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .en(state == IDLE),
    .req({bus.d_req, bus.if_req}),
    .gnt(gnt)
  );
  // grant, stream four bytes most-significant first, then pulse the owner's ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      owner <= PORT_IF;
      wd <= '0;
      word_q <= '0;
      bus.mem_addr <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= '0;
      bus.if_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (|gnt) begin
            owner <= gnt[1];
            cnt <= '0;
            wd <= gnt[1] ? bus.d_wdata[23:0] : '0;
            bus.mem_addr <= gnt[1] ? bus.d_addr : bus.if_addr;
            bus.mem_we <= gnt[1] & bus.d_we;
            bus.mem_wdata <= (gnt[1] & bus.d_we) ? bus.d_wdata[31:24] : '0;
            state <= XFER;
          end
        XFER: begin
          if (!bus.mem_we) word_q <= {word_q[15:0], bus.mem_rdata};
          cnt <= cnt + 2'd1;
          wd <= wd << 8;
          if (cnt == LAST) begin
            bus.mem_addr <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_wdata <= '0;
            bus.if_ack <= owner == PORT_IF;
            bus.d_ack <= owner == PORT_D;
            bus.if_rdata <= owner == PORT_IF ? {word_q, bus.mem_rdata} : '0;
            bus.d_rdata <= (owner == PORT_D && !bus.mem_we) ? {word_q, bus.mem_rdata} : '0;
            state <= DONE;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            bus.mem_wdata <= bus.mem_we ? wd[23:16] : '0;
          end
        end
        default: begin
          cnt <= '0;
          bus.if_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.if_rdata <= '0;
          bus.d_rdata <= '0;
          state <= IDLE;
        end
      endcase
    end
endmodule
